// File: rtl/mult_bcd_pkg.sv
// Shared types and helpers for the multiplier result BCD converter.
// Holds the FSM encoding, default sizes and the 7-segment digit decode.
package mult_bcd_pkg;

  localparam int BCD_WIDTH  = 16;
  localparam int BCD_DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } bcd_state_t;

  // Segment order is g,f,e,d,c,b,a from bit 6 down to bit 0.
  function automatic logic [6:0] seg7_decode(
    input logic [3:0] d
  );
    logic [6:0] s;
    s = 7'b0000000;
    case (d)
      4'd0: s = 7'b0111111;
      4'd1: s = 7'b0000110;
      4'd2: s = 7'b1011011;
      4'd3: s = 7'b1001111;
      4'd4: s = 7'b1100110;
      4'd5: s = 7'b1101101;
      4'd6: s = 7'b1111101;
      4'd7: s = 7'b0000111;
      4'd8: s = 7'b1111111;
      4'd9: s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mult_result_bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
// Purely combinational, 4 bits wide, no carry out.
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/mult_result_bcd.sv
// Sequential binary-to-BCD converter fed by the shift-add multiplier.
// Define BCD_SEG7_EN to add the registered-digit 7-segment output seg.
module mult_result_bcd
  import mult_bcd_pkg::*;
#(
  parameter int WIDTH  = BCD_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      result,
  input  logic                  d_end,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
`ifdef BCD_SEG7_EN
  ,
  output logic [7*DIGITS-1:0]   seg
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  bcd_state_t    state_q, state_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic [BW-1:0] adj;
  logic          d_end_q;
  logic          start;

  // Scratch digits live above the binary bits in one shift register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (sh_q[WIDTH+4*g +: 4]),
      .d_o (adj[4*g +: 4])
    );
  end

  assign start = d_end & ~d_end_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CONV;
          sh_d    = {{BW{1'b0}}, result};
          cnt_d   = '0;
        end
      end
      CONV: begin
        sh_d  = {adj, sh_q[WIDTH-1:0]} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          bcd_d   = sh_d[SW-1:WIDTH];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      d_end_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      d_end_q <= d_end;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

`ifdef BCD_SEG7_EN
  for (genvar s = 0; s < DIGITS; s++) begin : g_seg
    assign seg[7*s +: 7] = seg7_decode(bcd_q[4*s +: 4]);
  end
`endif

endmodule

// File: doc/mult_result_bcd.md
# mult_result_bcd

Sequential binary-to-BCD converter that sits directly downstream of `shift_add_multiplier`. It captures the 16-bit product when the multiplier's completion flag rises and converts it to five packed BCD digits using iterative shift-and-add-3 (double dabble), one bit per clock. It holds the converted digits for the display/report stage and flags each new value with a one-cycle `done` pulse.

## Interface
Parameters:
- `WIDTH`, 16: binary input width.
- `DIGITS`, 5: number of BCD digits. Must satisfy 10^DIGITS > 2^WIDTH − 1.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `result`  in  WIDTH: binary value; connects to the multiplier's `result`.
- `d_end`  in  1: completion flag; connects to the multiplier's `d_end`. It may be a pulse or a held level.
- `busy`  out  1: high while a conversion is in progress.
- `bcd`  out  4*DIGITS: packed digits. Digit 0 is the least significant, in `bcd[3:0]`.
- `done`  out  1: one-cycle pulse when `bcd` has been updated.
- `seg`  out  7*DIGITS: present only with `BCD_SEG7_EN`.

## Operation
- Trigger:
  - `d_end_q` is a registered copy of `d_end`.
  - A start occurs when `d_end && !d_end_q` is true in IDLE.
  - Holding `d_end` high produces exactly one start.
- FSM states: IDLE, CONV, DONE.
  - IDLE → CONV on start. On that edge, `result` is loaded into a WIDTH-bit binary shift register, the 4*DIGITS scratch register is cleared, and the iteration counter is cleared.
  - CONV, each cycle:
    - add 3 to every scratch nibble ≥ 5;
    - shift {scratch, binary} left by one;
    - increment the counter.
  - CONV → DONE on the edge that performs iteration WIDTH (counter reaching WIDTH−1 beforehand). On that same edge the final scratch value is written to `bcd`.
  - DONE → IDLE unconditionally after one cycle.
- Outputs:
  - `busy` is high in CONV and DONE.
  - `done` is high only in DONE.
- Input handling:
  - `result` is sampled only at the load edge. Later changes do not affect the conversion in progress.
  - Rising edges of `d_end` seen in CONV or DONE are ignored and not queued. `d_end_q` still tracks `d_end`.
- `bcd` holds its last value until the next conversion completes. It is never partially updated.
- Arithmetic:
  - The add-3 correction is per nibble and 4-bit wide. No carry crosses nibbles.
  - The shift carries bit 3 of each nibble into bit 0 of the next nibble.
  - The MSB of `binary` shifts into scratch bit 0.

## Timing
- Reset values:
  - state = IDLE, `busy` = 0, `done` = 0, `bcd` = 0, counter = 0.
  - `d_end_q` = 1, so a `d_end` held high across reset does not trigger a start. A fresh rising edge is required.
  - `seg` decodes `bcd` = 0, i.e. all digits show "0".
- Latency:
  - Load edge L. Iterations run on edges L+1 … L+WIDTH.
  - `done` and the new `bcd` are visible in the cycle after edge L+WIDTH (16 cycles after the load edge at default width).
  - `done` drops after edge L+WIDTH+1.
- Throughput: one conversion per WIDTH+2 cycles. The earliest next load edge is L+WIDTH+2.
- Reset mid-conversion: the partial conversion is discarded; no `done` is produced.
- Simultaneous `rst` and a rising `d_end`: reset wins.

## Configuration
- `BCD_SEG7_EN` defined:
  - Adds port `seg`, a combinational decode of registered `bcd`.
  - Digit i occupies `seg[7i+6:7i]`, ordered g,f,e,d,c,b,a, active-high.
  - Nibble values 10–15 decode to all-off.
- `BCD_SEG7_EN` undefined: the `seg` port and its decode logic are absent. All other behaviour is identical.

## Structure
- Package `mult_bcd_pkg`:
  - state enum `bcd_state_t` (IDLE, CONV, DONE);
  - default `WIDTH` and `DIGITS` localparams;
  - function `seg7_decode` (4-bit → 7-bit).
- Sub-module `bcd_digit_adj`: combinational 4-bit add-3-if-≥5, instantiated DIGITS times via generate.
- Counter width is $clog2(WIDTH).

## Test plan
- Reset with `d_end` held at 0 → `busy`=0, `done`=0, `bcd`=20'h00000 after the first edge.
- `result`=34170, one-cycle `d_end` pulse → `done` high for exactly one cycle, 16 cycles after the load edge, with `bcd`=20'h34170. Also check `result`=65025 → 20'h65025, `result`=0 → 20'h00000, and `result`=255 → 20'h00255.
- `d_end` held high for 40 cycles with `result` changed mid-conversion → exactly one `done`. `bcd` reflects the value present at the load edge.
- Second rising edge of `d_end` during CONV → ignored: no second `done`, `bcd` unchanged.
- `rst` asserted at iteration 8 with `d_end` held high through and after reset → `busy`=0, `bcd`=0, no `done`. A subsequent low→high `d_end` starts a normal conversion.
- With `BCD_SEG7_EN`, `result`=255 → `seg[6:0]`=7'b1101101 ("5"), `seg[13:7]`=7'b1101101 ("5"), `seg[20:14]`=7'b1011011 ("2"), upper two digits 7'b0111111 ("0").
